// File: rtl/tile_map.sv
// tile_map
//   Tile-map store and lookup stage feeding tile_data. Each 16x16 px cell of
//   the LCD has a 9-bit entry {tile[3:0], mirror[1:0], rotate[2:0]} stored in
//   an inferred block RAM at address row*MAP_W + col. After reset an init
//   sequencer writes the default border pattern, one entry per cycle, then the
//   block switches to RUN where lookups and game-logic writes are serviced.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_x, i_y            pixel coordinate; cell = {i_x[8:4], i_y[8:4]}
//   o_tile/o_mirror/
//   o_rotate            entry of the cell presented two cycles earlier
//   o_valid             lookup outputs are meaningful (RUN)
//   i_wr_valid/
//   o_wr_ready          write handshake (ready only in RUN, no backpressure)
//   i_wr_col/i_wr_row   target cell of a write
//   i_wr_tile/mirror/
//   rotate              entry to store
//   o_wr_err            one-cycle pulse after an accepted out-of-range write
//   o_init_done         default fill complete
module tile_map #(
    parameter int MAP_W       = 30,
    parameter int MAP_H       = 17,
    parameter int CORNER_TILE = 6,
    parameter int BORDER_TILE = 8,
    parameter int FILL_TILE   = 12
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [8:0] i_x,
    input  logic [8:0] i_y,
    output logic [3:0] o_tile,
    output logic [1:0] o_mirror,
    output logic [2:0] o_rotate,
    output logic       o_valid,
    input  logic       i_wr_valid,
    output logic       o_wr_ready,
    input  logic [4:0] i_wr_col,
    input  logic [4:0] i_wr_row,
    input  logic [3:0] i_wr_tile,
    input  logic [1:0] i_wr_mirror,
    input  logic [2:0] i_wr_rotate,
    output logic       o_wr_err,
    output logic       o_init_done
);

    localparam int         DEPTH     = MAP_W * MAP_H;
    localparam logic [8:0] LAST_ADDR = 9'(DEPTH - 1);
    localparam logic [8:0] MAP_W_9   = 9'(MAP_W);
    localparam logic [4:0] MAP_W_5   = 5'(MAP_W);
    localparam logic [4:0] MAP_H_5   = 5'(MAP_H);
    localparam logic [3:0] CORNER_4  = 4'(CORNER_TILE);
    localparam logic [3:0] BORDER_4  = 4'(BORDER_TILE);
    localparam logic [3:0] FILL_4    = 4'(FILL_TILE);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t     state_reg, state_next;
    logic [8:0] fill_n_reg, fill_n_next;
    logic [4:0] fill_col_reg, fill_col_next;
    logic       run;
    logic       fill_we;
    logic [8:0] fill_data;

    // Pixel offsets within a cell do not affect the lookup.
    logic unused_pixel_bits;
    assign unused_pixel_bits = ^{i_x[3:0], i_y[3:0]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= ST_INIT;
            fill_n_reg   <= '0;
            fill_col_reg <= '0;
        end else begin
            state_reg    <= state_next;
            fill_n_reg   <= fill_n_next;
            fill_col_reg <= fill_col_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        fill_n_next   = fill_n_reg;
        fill_col_next = fill_col_reg;
        run           = 1'b0;
        fill_we       = 1'b0;
        case (state_reg)
            ST_INIT: begin
                fill_we       = 1'b1;
                fill_n_next   = fill_n_reg + 9'd1;
                // Column tracked alongside the linear address so the border
                // decode needs no divider.
                fill_col_next = (fill_col_reg == MAP_W_5 - 5'd1) ? 5'd0 : fill_col_reg + 5'd1;
                if (fill_n_reg == LAST_ADDR) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                run = 1'b1;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // Default pattern: corner at (0,0), border along row 0 and column 0
    // (column-0 border rotated by 3), fill everywhere else; mirror always 0.
    always_comb begin
        if (fill_n_reg == 9'd0) begin
            fill_data = {CORNER_4, 2'd0, 3'd0};
        end else if (fill_n_reg < MAP_W_9) begin
            fill_data = {BORDER_4, 2'd0, 3'd0};
        end else if (fill_col_reg == 5'd0) begin
            fill_data = {BORDER_4, 2'd0, 3'd3};
        end else begin
            fill_data = {FILL_4, 2'd0, 3'd0};
        end
    end

    assign o_valid     = run;
    assign o_wr_ready  = run;
    assign o_init_done = run;

    // Write request decode
    logic       wr_accept;
    logic       wr_oor;
    logic [8:0] wr_addr;
    assign wr_accept = i_wr_valid && run;
    assign wr_oor    = (i_wr_col >= MAP_W_5) || (i_wr_row >= MAP_H_5);
    assign wr_addr   = 9'(i_wr_row) * MAP_W_9 + 9'(i_wr_col);

    // Lookup decode; out-of-range cells read address 0 and are masked later.
    logic [4:0] lk_col, lk_row;
    logic       lk_oor;
    logic [8:0] lk_addr;
    assign lk_col  = i_x[8:4];
    assign lk_row  = i_y[8:4];
    assign lk_oor  = (lk_col >= MAP_W_5) || (lk_row >= MAP_H_5);
    assign lk_addr = lk_oor ? 9'd0 : 9'(lk_row) * MAP_W_9 + 9'(lk_col);

    logic [8:0] mem [0:DEPTH-1];
    logic       we_reg;
    logic [8:0] waddr_reg;
    logic [8:0] wdata_reg;
    logic       err_reg;
    logic [8:0] rd_addr_reg;
    logic       rd_oor_reg;
    logic [8:0] rd_data_reg;
    logic       rd_oor2_reg;

    // Writes are committed one cycle late, in the same edge as the RAM read
    // of a lookup issued alongside them. That read therefore still sees the
    // old entry, and lookups from the following cycle see the new one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            we_reg      <= 1'b0;
            waddr_reg   <= '0;
            wdata_reg   <= '0;
            err_reg     <= 1'b0;
            rd_addr_reg <= '0;
            rd_oor_reg  <= 1'b0;
            rd_data_reg <= '0;
            rd_oor2_reg <= 1'b0;
        end else begin
            we_reg      <= fill_we || (wr_accept && !wr_oor);
            waddr_reg   <= fill_we ? fill_n_reg : wr_addr;
            wdata_reg   <= fill_we ? fill_data : {i_wr_tile, i_wr_mirror, i_wr_rotate};
            err_reg     <= wr_accept && wr_oor;
            rd_addr_reg <= lk_addr;
            rd_oor_reg  <= lk_oor;
            rd_data_reg <= mem[rd_addr_reg];
            rd_oor2_reg <= rd_oor_reg;
        end
    end

    always_ff @(posedge i_clk) begin
        if (we_reg) begin
            mem[waddr_reg] <= wdata_reg;
        end
    end

    assign o_tile   = rd_oor2_reg ? FILL_4 : rd_data_reg[8:5];
    assign o_mirror = rd_oor2_reg ? 2'd0   : rd_data_reg[4:3];
    assign o_rotate = rd_oor2_reg ? 3'd0   : rd_data_reg[2:0];
    assign o_wr_err = err_reg;

endmodule

// File: tb/tb_tile_map.sv
// tb_tile_map
//   Self-checking bench for tile_map: reset/init timing, a directed vector
//   table, randomized traffic against a cell-array reference model, and
//   resets during RUN and mid-INIT.
module tb_tile_map;

    localparam int         MAP_W = 30;
    localparam int         MAP_H = 17;
    localparam logic [3:0] FILL  = 4'd12;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [8:0] i_x, i_y;
    logic [3:0] o_tile;
    logic [1:0] o_mirror;
    logic [2:0] o_rotate;
    logic       o_valid;
    logic       i_wr_valid;
    logic       o_wr_ready;
    logic [4:0] i_wr_col, i_wr_row;
    logic [3:0] i_wr_tile;
    logic [1:0] i_wr_mirror;
    logic [2:0] i_wr_rotate;
    logic       o_wr_err;
    logic       o_init_done;

    always #5 clk = ~clk;

    tile_map #(
        .MAP_W(MAP_W), .MAP_H(MAP_H), .CORNER_TILE(6), .BORDER_TILE(8), .FILL_TILE(12)
    ) dut (
        .i_clk(clk), .i_rst(i_rst), .i_x(i_x), .i_y(i_y),
        .o_tile(o_tile), .o_mirror(o_mirror), .o_rotate(o_rotate), .o_valid(o_valid),
        .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
        .i_wr_col(i_wr_col), .i_wr_row(i_wr_row), .i_wr_tile(i_wr_tile),
        .i_wr_mirror(i_wr_mirror), .i_wr_rotate(i_wr_rotate),
        .o_wr_err(o_wr_err), .o_init_done(o_init_done)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference map indexed [row][col]
    logic [8:0] ref_map [MAP_H][MAP_W];
    logic [8:0] pend1, pend2;
    bit         pend1_chk, pend2_chk, err_pend;

    typedef struct {
        logic [8:0] x, y;
        logic       wv;
        logic [4:0] col, row;
        logic [3:0] tile;
        logic [1:0] mir;
        logic [2:0] rot;
        logic [3:0] e_tile;
        logic [1:0] e_mir;
        logic [2:0] e_rot;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void ref_init();
        for (int r = 0; r < MAP_H; r++) begin
            for (int c = 0; c < MAP_W; c++) begin
                if (r == 0 && c == 0)  ref_map[r][c] = {4'd6, 2'd0, 3'd0};
                else if (r == 0)       ref_map[r][c] = {4'd8, 2'd0, 3'd0};
                else if (c == 0)       ref_map[r][c] = {4'd8, 2'd0, 3'd3};
                else                   ref_map[r][c] = {4'd12, 2'd0, 3'd0};
            end
        end
    endfunction

    function automatic logic [8:0] ref_lookup(input logic [8:0] x, input logic [8:0] y);
        int c, r;
        c = int'(x) / 16;
        r = int'(y) / 16;
        if (c >= MAP_W || r >= MAP_H) return {FILL, 2'd0, 3'd0};
        return ref_map[r][c];
    endfunction

    // One RUN-state cycle: check outputs due now, then drive the next inputs.
    task automatic cyc(input logic [8:0] x, input logic [8:0] y, input logic wv,
                       input logic [4:0] col, input logic [4:0] row, input logic [3:0] tile,
                       input logic [1:0] mir, input logic [2:0] rot,
                       input logic [8:0] exp, input bit chk);
        int  c, r;
        bit  oor;
        if (pend2_chk) begin
            check("lookup_tile",   int'(o_tile),   int'(pend2[8:5]));
            check("lookup_mirror", int'(o_mirror), int'(pend2[4:3]));
            check("lookup_rotate", int'(o_rotate), int'(pend2[2:0]));
        end
        check("wr_err", int'(o_wr_err), int'(err_pend));
        check("run_flags", int'({o_init_done, o_wr_ready, o_valid}), 7);
        i_x = x; i_y = y;
        i_wr_valid = wv; i_wr_col = col; i_wr_row = row;
        i_wr_tile = tile; i_wr_mirror = mir; i_wr_rotate = rot;
        c = int'(col);
        r = int'(row);
        oor = (c >= MAP_W) || (r >= MAP_H);
        if (wv && !oor) ref_map[r][c] = {tile, mir, rot};
        err_pend  = wv && oor;
        pend2     = pend1;
        pend2_chk = pend1_chk;
        pend1     = exp;
        pend1_chk = chk;
        $display("txn t=%0t x=%0d y=%0d wr=%0b col=%0d row=%0d data=%0d/%0d/%0d expect=%0d/%0d/%0d",
                 $time, x, y, wv, col, row, tile, mir, rot, exp[8:5], exp[4:3], exp[2:0]);
        @(posedge clk); #1;
    endtask

    // Reset for one cycle, then follow the fill for stop_k cycles with a write
    // held pending the whole time (it must never be accepted).
    task automatic do_init(input int stop_k);
        i_rst = 1'b1;
        i_wr_valid = 1'b1; i_wr_col = 5'd3; i_wr_row = 5'd2;
        i_wr_tile = 4'd1; i_wr_mirror = 2'd1; i_wr_rotate = 3'd1;
        i_x = 9'd48; i_y = 9'd32;
        @(posedge clk); #1;
        i_rst = 1'b0;
        for (int k = 1; k <= stop_k; k++) begin
            if (k == 1) begin
                check("reset_tile",   int'(o_tile),   0);
                check("reset_mirror", int'(o_mirror), 0);
                check("reset_rotate", int'(o_rotate), 0);
            end
            check("init_flags", int'({o_init_done, o_wr_ready, o_valid}), (k >= 511) ? 7 : 0);
            check("init_wr_err", int'(o_wr_err), 0);
            if (k == 510) i_wr_valid = 1'b0;
            @(posedge clk); #1;
        end
        pend1_chk = 1'b0;
        pend2_chk = 1'b0;
        err_pend  = 1'b0;
        ref_init();
        $display("reset sequence: %0d cycles followed after release", stop_k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] rx, ry, e;
        logic       rwv;
        logic [4:0] rc, rr;

        //            x        y        wv    col    row    tile   mir    rot    e_tile  e_mir  e_rot
        tbl[0]  = '{9'd0,   9'd0,   1'b0, 5'd0,  5'd0,  4'd0, 2'd0, 3'd0, 4'd6,  2'd0, 3'd0};
        tbl[1]  = '{9'd16,  9'd0,   1'b0, 5'd0,  5'd0,  4'd0, 2'd0, 3'd0, 4'd8,  2'd0, 3'd0};
        tbl[2]  = '{9'd0,   9'd16,  1'b0, 5'd0,  5'd0,  4'd0, 2'd0, 3'd0, 4'd8,  2'd0, 3'd3};
        tbl[3]  = '{9'd40,  9'd40,  1'b0, 5'd0,  5'd0,  4'd0, 2'd0, 3'd0, 4'd12, 2'd0, 3'd0};
        tbl[4]  = '{9'd48,  9'd32,  1'b1, 5'd3,  5'd2,  4'd5, 2'd2, 3'd1, 4'd12, 2'd0, 3'd0};
        tbl[5]  = '{9'd48,  9'd32,  1'b0, 5'd0,  5'd0,  4'd0, 2'd0, 3'd0, 4'd5,  2'd2, 3'd1};
        tbl[6]  = '{9'd48,  9'd32,  1'b1, 5'd3,  5'd2,  4'd9, 2'd0, 3'd0, 4'd5,  2'd2, 3'd1};
        tbl[7]  = '{9'd48,  9'd32,  1'b0, 5'd0,  5'd0,  4'd0, 2'd0, 3'd0, 4'd9,  2'd0, 3'd0};
        tbl[8]  = '{9'd480, 9'd0,   1'b1, 5'd30, 5'd0,  4'd7, 2'd3, 3'd7, 4'd12, 2'd0, 3'd0};
        tbl[9]  = '{9'd464, 9'd0,   1'b0, 5'd0,  5'd0,  4'd0, 2'd0, 3'd0, 4'd8,  2'd0, 3'd0};
        tbl[10] = '{9'd0,   9'd271, 1'b0, 5'd0,  5'd0,  4'd0, 2'd0, 3'd0, 4'd8,  2'd0, 3'd3};
        tbl[11] = '{9'd479, 9'd271, 1'b0, 5'd0,  5'd0,  4'd0, 2'd0, 3'd0, 4'd12, 2'd0, 3'd0};
        tbl[12] = '{9'd0,   9'd272, 1'b0, 5'd0,  5'd0,  4'd0, 2'd0, 3'd0, 4'd12, 2'd0, 3'd0};
        tbl[13] = '{9'd511, 9'd511, 1'b1, 5'd0,  5'd17, 4'd1, 2'd1, 3'd1, 4'd12, 2'd0, 3'd0};
        tbl[14] = '{9'd479, 9'd271, 1'b1, 5'd29, 5'd16, 4'd3, 2'd1, 3'd7, 4'd12, 2'd0, 3'd0};
        tbl[15] = '{9'd479, 9'd271, 1'b0, 5'd0,  5'd0,  4'd0, 2'd0, 3'd0, 4'd3,  2'd1, 3'd7};

        i_rst = 1'b1;
        i_x = '0; i_y = '0;
        i_wr_valid = 1'b0; i_wr_col = '0; i_wr_row = '0;
        i_wr_tile = '0; i_wr_mirror = '0; i_wr_rotate = '0;
        pend1 = '0; pend2 = '0;
        pend1_chk = 1'b0; pend2_chk = 1'b0; err_pend = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Power-up fill with a write held pending throughout
        do_init(512);

        // Directed vectors
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].x, tbl[i].y, tbl[i].wv, tbl[i].col, tbl[i].row,
                tbl[i].tile, tbl[i].mir, tbl[i].rot,
                {tbl[i].e_tile, tbl[i].e_mir, tbl[i].e_rot}, 1'b1);
        end

        // Randomized traffic against the reference map
        for (int t = 0; t < 400; t++) begin
            rx  = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(480, 511)) : 9'($urandom_range(0, 479));
            ry  = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(272, 511)) : 9'($urandom_range(0, 271));
            rwv = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) begin
                rc = 5'(int'(rx) / 16);
                rr = 5'(int'(ry) / 16);
            end else begin
                rc = 5'($urandom_range(0, 31));
                rr = 5'($urandom_range(0, 18));
            end
            e = ref_lookup(rx, ry);
            cyc(rx, ry, rwv, rc, rr, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                3'($urandom_range(0, 7)), e, 1'b1);
        end

        // Reset in RUN, then again mid-INIT at n=200
        do_init(200);
        do_init(512);

        cyc(9'd48, 9'd32, 1'b0, 5'd0, 5'd0, 4'd0, 2'd0, 3'd0, {4'd12, 2'd0, 3'd0}, 1'b1);
        cyc(9'd479, 9'd271, 1'b0, 5'd0, 5'd0, 4'd0, 2'd0, 3'd0, {4'd12, 2'd0, 3'd0}, 1'b1);
        cyc(9'd0, 9'd0, 1'b0, 5'd0, 5'd0, 4'd0, 2'd0, 3'd0, {4'd6, 2'd0, 3'd0}, 1'b1);
        for (int t = 0; t < 100; t++) begin
            rx  = 9'($urandom_range(0, 511));
            ry  = 9'($urandom_range(0, 300));
            rwv = ($urandom_range(0, 1) == 0);
            rc  = 5'($urandom_range(0, 31));
            rr  = 5'($urandom_range(0, 18));
            e   = ref_lookup(rx, ry);
            cyc(rx, ry, rwv, rc, rr, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                3'($urandom_range(0, 7)), e, 1'b1);
        end

        // Drain the pipeline
        cyc(9'd0, 9'd0, 1'b0, 5'd0, 5'd0, 4'd0, 2'd0, 3'd0, 9'd0, 1'b0);
        cyc(9'd0, 9'd0, 1'b0, 5'd0, 5'd0, 4'd0, 2'd0, 3'd0, 9'd0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
